// File: rtl/ins_loader_pkg.sv
// Shared types and constants for the instruction loader.
// LOADER_CHECKSUM_EN adds the CHECK state and a trailing 4-byte checksum.
package ins_loader_pkg;

    localparam int unsigned HDR_BYTES         = 4;
    localparam int unsigned CHK_BYTES         = 4;
    localparam int unsigned DEFAULT_MAX_WORDS = 1000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHeader = 3'd1,
        StData   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        StCheck  = 3'd3,
`endif
        StDone   = 3'd4,
        StError  = 3'd5
    } state_t;

endpackage

// File: rtl/ins_loader_word_assembler.sv
// Collects consumed bytes into little-endian 32-bit words.
// o_word presents the word including the byte consumed this cycle.
module word_assembler
    import ins_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_consume,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [31:0] w_word;

    always_comb begin
        w_word = r_word;
        w_word[{r_idx, 3'b000} +: 8] = i_byte;
    end

    assign o_word = w_word;
    assign o_last = i_consume && (r_idx == 2'(HDR_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_consume) begin
            r_word <= w_word;
            r_idx  <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/ins_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the core.
// LOADER_CHECKSUM_EN: verify a trailing mod-2^32 word sum before releasing the core.
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_count;
    logic [15:0] r_words;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic        w_accept;
    logic        w_consume;
    logic        w_last;
    logic        w_last_word;
    logic [31:0] w_word;

    assign w_accept    = start && ((r_state == StIdle) || (r_state == StDone) ||
                                   (r_state == StError));
    assign w_consume   = rx_valid && rx_ready;
    assign w_last_word = (({16'd0, r_words} + 32'd1) == r_count);

    word_assembler u_asm (
        .i_clk     (SYS_clk),
        .i_reset   (SYS_reset),
        .i_clear   (w_accept),
        .i_consume (w_consume),
        .i_byte    (rx_data),
        .o_word    (w_word),
        .o_last    (w_last)
    );

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (start) w_state_next = StHeader;
            end
            StHeader: begin
                if (w_last) begin
                    if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_state_next = StCheck;
`else
                        w_state_next = StDone;
`endif
                    end else if (w_word > MAX_WORDS) begin
                        w_state_next = StError;
                    end else begin
                        w_state_next = StData;
                    end
                end
            end
            StData: begin
                if (r_we && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = StCheck;
`else
                    w_state_next = StDone;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (w_last) w_state_next = (w_word == r_sum) ? StDone : StError;
            end
`endif
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_count <= 32'd0;
            r_words <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= 32'd0;
`endif
        end else if (w_accept) begin
            r_we    <= 1'b0;
            r_words <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= 32'd0;
`endif
        end else begin
            if (r_state == StHeader && w_last) r_count <= w_word;
            if (r_state == StData) begin
                // The write cycle stalls rx, so no byte can land while r_we is high.
                if (r_we) begin
                    r_we    <= 1'b0;
                    r_words <= r_words + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    r_sum   <= r_sum + r_wdata;
`endif
                end else if (w_last) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        unique case (r_state)
            StHeader, StData: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            StCheck:          busy = 1'b1;
`endif
            default:          busy = 1'b0;
        endcase
    end

    assign rx_ready     = busy && !r_we;
    assign mem_we       = r_we;
    assign mem_addr     = r_we ? {14'd0, r_words, 2'b00} : 32'd0;
    assign mem_wdata    = r_we ? r_wdata : 32'd0;
    assign done         = (r_state == StDone);
    assign error        = (r_state == StError);
    assign cpu_hold     = (r_state != StDone);
    assign words_loaded = r_words;

endmodule

// File: tb/tb_ins_loader.sv
// Directed self-checking bench for ins_loader; checksum cases build only with LOADER_CHECKSUM_EN.
module tb_ins_loader;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cnt   = 0;
    int          bus_viol = 0;

    always #5 SYS_clk = ~SYS_clk;

    ins_loader #(.MAX_WORDS(1000)) dut (
        .SYS_clk      (SYS_clk),
        .SYS_reset    (SYS_reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // One sample per cycle, so a stretched strobe shows up as an extra write.
    always @(negedge SYS_clk) begin
        if (mem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
            if (rx_ready) bus_viol++;
        end else if (mem_addr != 32'd0 || mem_wdata != 32'd0) begin
            bus_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge SYS_clk);
            n++;
        end
        if (n >= 50) chk("rx_timeout", 32'(n), 32'd0);
        @(negedge SYS_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[8*i +: 8]);
            if (gap) @(negedge SYS_clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge SYS_clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge SYS_clk);
            n++;
        end
        if (n >= 200) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        SYS_reset = 1'b1;
        repeat (2) @(negedge SYS_clk);
        SYS_reset = 1'b0;
    endtask

    int base;

    initial begin
        SYS_reset = 1'b1;
        start     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        @(negedge SYS_clk);
        do_reset();

        // Reset values
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);

        // Valid without ready in IDLE consumes nothing
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge SYS_clk);
        rx_valid = 1'b0;
        chk("idle_no_ready", 32'(rx_ready), 32'd0);

        // Two-word load
        base = wr_cnt;
        pulse_start();
        chk("hdr_busy", {29'd0, busy, done, error}, 32'b100);
        chk("hdr_ready", 32'(rx_ready), 32'd1);
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_00A6, 1'b0);
`endif
        wait_end("two_word_timeout");
        chk("two_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("two_addr0", wr_addr[base], 32'h0);
        chk("two_data0", wr_data[base], 32'h0000_0013);
        chk("two_addr1", wr_addr[base+1], 32'h4);
        chk("two_data1", wr_data[base+1], 32'h0010_0093);
        chk("two_flags", {29'd0, busy, done, error}, 32'b010);
        chk("two_hold", 32'(cpu_hold), 32'd0);
        chk("two_words", 32'(words_loaded), 32'd2);

        // Start from DONE, then oversize header
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_words", 32'(words_loaded), 32'd0);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        base = wr_cnt;
        send_word(32'h0000_03E9, 1'b0);
        @(negedge SYS_clk);
        chk("over_flags", {29'd0, busy, done, error}, 32'b001);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        chk("over_ready", 32'(rx_ready), 32'd0);
        chk("over_no_we", 32'(wr_cnt - base), 32'd0);

        // Max size is accepted (check header decision only, then reset out)
        pulse_start();
        send_word(32'd1000, 1'b0);
        chk("max_ok_flags", {29'd0, busy, done, error}, 32'b100);
        do_reset();

        // Gapped valid, one word
        base = wr_cnt;
        pulse_start();
        send_word(32'd1, 1'b1);
        send_word(32'h1234_5678, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h1234_5678, 1'b1);
`endif
        wait_end("gap_timeout");
        chk("gap_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("gap_addr", wr_addr[base], 32'h0);
        chk("gap_data", wr_data[base], 32'h1234_5678);
        chk("gap_done", 32'(done), 32'd1);

        // Start pulsed mid-DATA is ignored
        base = wr_cnt;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        pulse_start();
        chk("ign_words", 32'(words_loaded), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BEF0, 1'b0);
`endif
        wait_end("ign_timeout");
        chk("ign_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("ign_data0", wr_data[base], 32'hDEAD_BEEF);
        chk("ign_addr1", wr_addr[base+1], 32'h4);
        chk("ign_data1", wr_data[base+1], 32'h0000_0001);
        chk("ign_done", 32'(done), 32'd1);

        // Zero-length image
        pulse_start();
        send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        @(negedge SYS_clk);
        chk("zero_flags", {29'd0, busy, done, error}, 32'b010);
        chk("zero_words", 32'(words_loaded), 32'd0);

        // Reset after 6 bytes of a 3-word load, with start and valid held in reset
        base = wr_cnt;
        pulse_start();
        send_word(32'd3, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        SYS_reset = 1'b1;
        start     = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'hCC;
        @(negedge SYS_clk);
        chk("mid_rst_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_flags", {28'd0, cpu_hold, busy, done, error}, 32'b1000);
        chk("mid_rst_bus", mem_addr | mem_wdata | 32'(mem_we), 32'd0);
        SYS_reset = 1'b0;
        start     = 1'b0;
        repeat (6) @(negedge SYS_clk);
        rx_valid  = 1'b0;
        chk("mid_rst_idle", {29'd0, busy, done, error}, 32'b000);
        chk("mid_rst_no_we", 32'(wr_cnt - base), 32'd0);
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'h4433_2211, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h4433_2211, 1'b0);
`endif
        wait_end("reload_timeout");
        chk("reload_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("reload_addr", wr_addr[base], 32'h0);
        chk("reload_data", wr_data[base], 32'h4433_2211);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_word(32'h0010_00A7, 1'b0);
        wait_end("bad_sum_timeout");
        chk("bad_sum_flags", {29'd0, busy, done, error}, 32'b001);
        chk("bad_sum_hold", 32'(cpu_hold), 32'd1);
`endif

        chk("bus_rules", 32'(bus_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
